// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control FSM (package mc_pkg).
// Holds the state enum, opcode constants, select encodings and the packed control word.
package mc_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    RWB_R    = 4'd8,
    EXEC_I   = 4'd9,
    RWB_I    = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] PC_SEL_ALU  = 2'b00;
  localparam logic [1:0] PC_SEL_ALUR = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP = 2'b10;

  localparam logic [1:0] ALUSRCB_B    = 2'b00;
  localparam logic [1:0] ALUSRCB_4    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for multicycle_ctrl; master = controller, slave = datapath + memory.
// MC_CTRL_PERF_EN adds the instr_cnt/cycle_cnt performance counter signals.
interface multicycle_ctrl_if #(
  parameter int OPW = 6
`ifdef MC_CTRL_PERF_EN
  , parameter int PERF_W = 32
`endif
);

  // Memory handshake: mem_req is valid, mem_ready is ready; an access completes in a
  // cycle where both are high, and mem_req (with mem_we/iord) holds steady until then.
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           mem_req;
  logic           mem_we;
  logic           iord;
  logic           ir_write;
  logic           pc_write;
  logic [1:0]     pc_sel;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic           illegal;
`ifdef MC_CTRL_PERF_EN
  logic [PERF_W-1:0] instr_cnt;
  logic [PERF_W-1:0] cycle_cnt;
`endif

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_sel,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal
`ifdef MC_CTRL_PERF_EN
    , output instr_cnt, cycle_cnt
`endif
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_sel,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal
`ifdef MC_CTRL_PERF_EN
    , input instr_cnt, cycle_cnt
`endif
  );

endinterface

// File: rtl/multicycle_ctrl_perf_counters.sv
// Retired-instruction and cycle counters for multicycle_ctrl (module mc_perf_counters).
// Only compiled when MC_CTRL_PERF_EN is defined; both counters wrap modulo 2^PERF_W.
`ifdef MC_CTRL_PERF_EN
module mc_perf_counters #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_retire,
  output logic [PERF_W-1:0] o_instr_cnt,
  output logic [PERF_W-1:0] o_cycle_cnt
);

  logic [PERF_W-1:0] r_instr_cnt;
  logic [PERF_W-1:0] r_cycle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + PERF_W'(1);
      if (i_retire) r_instr_cnt <= r_instr_cnt + PERF_W'(1);
    end
  end

  assign o_instr_cnt = r_instr_cnt;
  assign o_cycle_cnt = r_cycle_cnt;

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-subset datapath with a stallable shared-memory handshake.
// Define MC_CTRL_PERF_EN to add the retired-instruction and cycle counters.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int OPW = 6
`ifdef MC_CTRL_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus,
  output state_t              o_state
);

  state_t         r_state;
  state_t         w_next;
  ctrl_t          w_ctrl;
  logic [OPW-1:0] w_opcode;

  assign w_opcode = bus.opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = FETCH;
      FETCH:    if (bus.mem_ready) w_next = DECODE;
      DECODE: begin
        case (w_opcode)
          OP_RTYPE:     w_next = EXEC_R;
          OP_LW, OP_SW: w_next = MEM_ADDR;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          OP_ADDI:      w_next = EXEC_I;
          default:      w_next = FETCH;
        endcase
      end
      // IR is stable from DECODE on, so the lw/sw split can still look at the opcode here.
      MEM_ADDR: w_next = (w_opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (bus.mem_ready) w_next = MEM_WB;
      MEM_WB:   w_next = FETCH;
      MEM_WR:   if (bus.mem_ready) w_next = FETCH;
      EXEC_R:   w_next = RWB_R;
      RWB_R:    w_next = FETCH;
      EXEC_I:   w_next = RWB_I;
      RWB_I:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      JUMP:     w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      FETCH: begin
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.mem_we    = 1'b0;
        w_ctrl.iord      = 1'b0;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = ALUSRCB_4;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_sel    = PC_SEL_ALU;
        // IR and PC may only update in the cycle the instruction word actually arrives.
        w_ctrl.ir_write  = bus.mem_ready;
        w_ctrl.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = ALUSRCB_IMM2;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.illegal   = !is_legal_op(w_opcode);
      end
      MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUSRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.iord    = 1'b1;
      end
      MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.mem_we  = 1'b1;
        w_ctrl.iord    = 1'b1;
      end
      EXEC_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUSRCB_B;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      RWB_R: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
      end
      EXEC_I: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUSRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      RWB_I: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
      end
      BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = ALUSRCB_B;
        w_ctrl.alu_op    = ALUOP_SUB;
        w_ctrl.pc_sel    = PC_SEL_ALUR;
        w_ctrl.pc_write  = bus.zero;
      end
      JUMP: begin
        w_ctrl.pc_sel   = PC_SEL_JUMP;
        w_ctrl.pc_write = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  assign bus.mem_req    = w_ctrl.mem_req;
  assign bus.mem_we     = w_ctrl.mem_we;
  assign bus.iord       = w_ctrl.iord;
  assign bus.ir_write   = w_ctrl.ir_write;
  assign bus.pc_write   = w_ctrl.pc_write;
  assign bus.pc_sel     = w_ctrl.pc_sel;
  assign bus.reg_dst    = w_ctrl.reg_dst;
  assign bus.mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.reg_write  = w_ctrl.reg_write;
  assign bus.alu_src_a  = w_ctrl.alu_src_a;
  assign bus.alu_src_b  = w_ctrl.alu_src_b;
  assign bus.alu_op     = w_ctrl.alu_op;
  assign bus.illegal    = w_ctrl.illegal;
  assign o_state        = r_state;

`ifdef MC_CTRL_PERF_EN
  logic w_retire;

  // An illegal opcode goes DECODE -> FETCH and is deliberately not counted as retired.
  assign w_retire = (w_next == FETCH) &&
                    (r_state inside {MEM_WB, MEM_WR, RWB_R, RWB_I, BRANCH, JUMP});

  mc_perf_counters #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_retire    (w_retire),
    .o_instr_cnt (bus.instr_cnt),
    .o_cycle_cnt (bus.cycle_cnt)
  );
`endif

endmodule
